// File: rtl/vga_fb_pixel_stream.sv
// rtl/vga_fb_pixel_stream.sv - framebuffer SRAM reader and pixel/sync output stage behind vga_sync
module vga_fb_pixel_stream #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 visible,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [9:0]           column,
    input  logic [9:0]           row,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic                 sram_rd_en,
    input  logic [DATA_BITS-1:0] sram_data,
    output logic [3:0]           vga_red,
    output logic [3:0]           vga_green,
    output logic [3:0]           vga_blue,
    output logic                 vga_hsync,
    output logic                 vga_vsync
);

    // Pipeline depth from timing input to DAC pins: address register,
    // SRAM latency, output register.
    localparam int P = READ_LATENCY + 2;

    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("vga_fb_pixel_stream: READ_LATENCY must be in 1..8");
    end

    if (longint'(H_VISIBLE) * longint'(V_VISIBLE) > (longint'(1) << ADDR_BITS)) begin : g_bad_addr
        $error("vga_fb_pixel_stream: ADDR_BITS too narrow for H_VISIBLE*V_VISIBLE");
    end

    logic [ADDR_BITS-1:0] next_addr;
    // Visible only needs P-1 stages: the colour register itself is the last one.
    logic [P-2:0]         vis_dly;
    logic [P-1:0]         hsync_dly;
    logic [P-1:0]         vsync_dly;
    logic                 frame_start;
    logic                 frame_done;

    assign frame_start = visible && (column == 10'd0) && (row == 10'd0);
    assign frame_done  = !visible && (32'(row) >= 32'(V_VISIBLE));

    // Linear read address: resync at top-left, step per visible pixel, clear in vertical blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_addr  <= '0;
            sram_addr  <= '0;
            sram_rd_en <= 1'b0;
        end else if (frame_start) begin
            sram_addr  <= '0;
            sram_rd_en <= 1'b1;
            next_addr  <= ADDR_BITS'(1);
        end else if (visible) begin
            sram_addr  <= next_addr;
            sram_rd_en <= 1'b1;
            next_addr  <= next_addr + 1'b1;
        end else begin
            sram_rd_en <= 1'b0;
            if (frame_done) begin
                next_addr <= '0;
            end
        end
    end

    // Delay visible and syncs so they line up with data returning from the SRAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            vis_dly   <= '0;
            hsync_dly <= '1;
            vsync_dly <= '1;
        end else begin
            vis_dly   <= {vis_dly[P-3:0], visible};
            hsync_dly <= {hsync_dly[P-2:0], hsync};
            vsync_dly <= {vsync_dly[P-2:0], vsync};
        end
    end

    // Colour register: unpack SRAM word while visible, force black in blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_red   <= 4'd0;
            vga_green <= 4'd0;
            vga_blue  <= 4'd0;
        end else if (vis_dly[P-2]) begin
            vga_red   <= sram_data[DATA_BITS-1 -: 4];
            vga_green <= sram_data[DATA_BITS-5 -: 4];
            vga_blue  <= sram_data[DATA_BITS-9 -: 4];
        end else begin
            vga_red   <= 4'd0;
            vga_green <= 4'd0;
            vga_blue  <= 4'd0;
        end
    end

    assign vga_hsync = hsync_dly[P-1];
    assign vga_vsync = vsync_dly[P-1];

endmodule

// File: tb/tb_vga_fb_pixel_stream.sv
// tb/tb_vga_fb_pixel_stream.sv - directed self-checking bench for vga_fb_pixel_stream
module tb_vga_fb_pixel_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       visible;
    logic       hsync;
    logic       vsync;
    logic [9:0] column;
    logic [9:0] row;
    logic       force_fff;

    // default build, 640x480, latency 2
    logic [19:0] addr_d;
    logic        rd_d;
    logic [11:0] data_d;
    logic [3:0]  r_d, g_d, b_d;
    logic        hs_d, vs_d;
    // small frame build, 16x6, latency 2
    logic [19:0] addr_s;
    logic        rd_s;
    logic [11:0] data_s;
    logic [3:0]  r_s, g_s, b_s;
    logic        hs_s, vs_s;
    // small frame build, 16x6, latency 5
    logic [19:0] addr_5;
    logic        rd_5;
    logic [11:0] data_5;
    logic [3:0]  r_5, g_5, b_5;
    logic        hs_5, vs_5;

    wire [11:0] col_d = {r_d, g_d, b_d};
    wire [11:0] col_s = {r_s, g_s, b_s};
    wire [11:0] col_5 = {r_5, g_5, b_5};

    int checks = 0;
    int errors = 0;

    int h_vis, h_tot, hs_beg, hs_end, v_vis, v_tot, vs_beg, vs_end;
    int row_cnt = 0;
    int col_cnt = 0;
    int cur_row = 0;
    int cur_col = 0;
    logic vh [0:7];
    logic hh [0:7];

    always #5 clk = ~clk;

    vga_fb_pixel_stream dut (
        .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
        .column(column), .row(row), .sram_addr(addr_d), .sram_rd_en(rd_d), .sram_data(data_d),
        .vga_red(r_d), .vga_green(g_d), .vga_blue(b_d), .vga_hsync(hs_d), .vga_vsync(vs_d)
    );

    vga_fb_pixel_stream #(.H_VISIBLE(16), .V_VISIBLE(6)) dut_s (
        .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
        .column(column), .row(row), .sram_addr(addr_s), .sram_rd_en(rd_s), .sram_data(data_s),
        .vga_red(r_s), .vga_green(g_s), .vga_blue(b_s), .vga_hsync(hs_s), .vga_vsync(vs_s)
    );

    vga_fb_pixel_stream #(.H_VISIBLE(16), .V_VISIBLE(6), .READ_LATENCY(5)) dut_5 (
        .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
        .column(column), .row(row), .sram_addr(addr_5), .sram_rd_en(rd_5), .sram_data(data_5),
        .vga_red(r_5), .vga_green(g_5), .vga_blue(b_5), .vga_hsync(hs_5), .vga_vsync(vs_5)
    );

    // SRAM models: data = address low bits (latency 5 model scrambles with 0xA5C)
    logic [11:0] pipe_d [0:1];
    logic [11:0] pipe_s [0:1];
    logic [11:0] pipe_5 [0:4];

    always_ff @(posedge clk) begin
        pipe_d[0] <= addr_d[11:0];
        pipe_d[1] <= pipe_d[0];
        pipe_s[0] <= addr_s[11:0];
        pipe_s[1] <= pipe_s[0];
        pipe_5[0] <= addr_5[11:0] ^ 12'hA5C;
        for (int i = 1; i < 5; i++) pipe_5[i] <= pipe_5[i-1];
    end

    assign data_d = force_fff ? 12'hFFF : pipe_d[1];
    assign data_s = force_fff ? 12'hFFF : pipe_s[1];
    assign data_5 = force_fff ? 12'hFFF : pipe_5[4];

    task automatic cfg_big();
        h_vis = 640; h_tot = 800; hs_beg = 656; hs_end = 752;
        v_vis = 480; v_tot = 525; vs_beg = 490; vs_end = 492;
    endtask

    task automatic cfg_small();
        h_vis = 16; h_tot = 24; hs_beg = 18; hs_end = 21;
        v_vis = 6;  v_tot = 9;  vs_beg = 7;  vs_end = 8;
    endtask

    // One pixel clock: inputs for the position in row_cnt/col_cnt are applied, outputs sampled after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 7; i > 0; i--) begin
            vh[i] = vh[i-1];
            hh[i] = hh[i-1];
        end
        cur_row = row_cnt;
        cur_col = col_cnt;
        visible = (col_cnt < h_vis) && (row_cnt < v_vis);
        hsync   = !((col_cnt >= hs_beg) && (col_cnt < hs_end));
        vsync   = !((row_cnt >= vs_beg) && (row_cnt < vs_end));
        column  = 10'(col_cnt);
        row     = 10'(row_cnt);
        vh[0]   = visible;
        hh[0]   = hsync;
        col_cnt++;
        if (col_cnt == h_tot) begin
            col_cnt = 0;
            row_cnt++;
            if (row_cnt == v_tot) row_cnt = 0;
        end
    endtask

    task automatic run_to(input int r, input int c, input int limit);
        int n;
        n = 0;
        tick();
        while (!(cur_row == r && cur_col == c) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            $display("FAIL run_to(%0d,%0d): position not reached within %0d cycles", r, c, limit);
            errors++;
        end
    endtask

    task automatic test_reset();
        cfg_big();
        reset = 1'b1;
        row_cnt = 520;
        col_cnt = 0;
        repeat (3) tick();
        checks++; if (addr_d !== 20'd0) begin $display("FAIL reset_addr: got %0d want 0", addr_d); errors++; end
        checks++; if (rd_d !== 1'b0) begin $display("FAIL reset_rd_en: got %b want 0", rd_d); errors++; end
        checks++; if (col_d !== 12'h000) begin $display("FAIL reset_colour: got %h want 000", col_d); errors++; end
        checks++; if (hs_d !== 1'b1) begin $display("FAIL reset_hsync: got %b want 1", hs_d); errors++; end
        checks++; if (vs_d !== 1'b1) begin $display("FAIL reset_vsync: got %b want 1", vs_d); errors++; end
        checks++; if (dut.next_addr !== 20'd0) begin $display("FAIL reset_next_addr: got %0d want 0", dut.next_addr); errors++; end
        checks++; if (hs_5 !== 1'b1 || col_5 !== 12'h000) begin $display("FAIL reset_lat5: got hs %b col %h want 1/000", hs_5, col_5); errors++; end
        reset = 1'b0;
    endtask

    task automatic test_first_pixel();
        run_to(0, 0, 5000);
        tick();
        checks++; if (addr_d !== 20'd0 || rd_d !== 1'b1) begin $display("FAIL first_read: got addr %0d rd %b want 0/1", addr_d, rd_d); errors++; end
        tick();
        checks++; if (addr_d !== 20'd1) begin $display("FAIL second_read: got %0d want 1", addr_d); errors++; end
        tick();
        tick();
        checks++; if (col_d !== 12'h000) begin $display("FAIL pixel0: got %h want 000", col_d); errors++; end
        tick();
        checks++; if (col_d !== 12'h001) begin $display("FAIL pixel1: got %h want 001", col_d); errors++; end
        tick();
        checks++; if (col_d !== 12'h002) begin $display("FAIL pixel2: got %h want 002", col_d); errors++; end
    endtask

    task automatic test_line_boundary();
        int bad;
        bad = 0;
        run_to(0, 639, 1000);
        tick();
        checks++; if (addr_d !== 20'd639 || rd_d !== 1'b1) begin $display("FAIL last_read_row0: got addr %0d rd %b want 639/1", addr_d, rd_d); errors++; end
        for (int i = 0; i < 160; i++) begin
            tick();
            if (rd_d !== 1'b0 || addr_d !== 20'd639) bad++;
            if (i == 2) begin
                checks++; if (col_d !== 12'h27F) begin $display("FAIL pixel639: got %h want 27f", col_d); errors++; end
            end
            if (i == 3) begin
                checks++; if (col_d !== 12'h000) begin $display("FAIL hblank_first: got %h want 000", col_d); errors++; end
            end
        end
        checks++; if (bad != 0) begin $display("FAIL hblank_hold: got %0d bad cycles want 0", bad); errors++; end
        tick();
        checks++; if (addr_d !== 20'd640 || rd_d !== 1'b1) begin $display("FAIL first_read_row1: got addr %0d rd %b want 640/1", addr_d, rd_d); errors++; end
    endtask

    task automatic test_alignment();
        int fin;
        int fout;
        fin = -1;
        fout = -1;
        run_to(1, 600, 1000);
        force_fff = 1'b1;
        for (int i = 0; i < 250; i++) begin
            tick();
            checks++; if (col_d !== (vh[4] ? 12'hFFF : 12'h000)) begin $display("FAIL align_colour cyc %0d: got %h want %h", i, col_d, vh[4] ? 12'hFFF : 12'h000); errors++; end
            checks++; if (hs_d !== hh[4]) begin $display("FAIL align_hsync cyc %0d: got %b want %b", i, hs_d, hh[4]); errors++; end
            checks++; if (col_5 !== (vh[7] ? 12'hFFF : 12'h000)) begin $display("FAIL align_colour_lat5 cyc %0d: got %h want %h", i, col_5, vh[7] ? 12'hFFF : 12'h000); errors++; end
            checks++; if (hs_5 !== hh[7]) begin $display("FAIL align_hsync_lat5 cyc %0d: got %b want %b", i, hs_5, hh[7]); errors++; end
            if (fin < 0 && hh[0] == 1'b0 && hh[1] == 1'b1) fin = i;
            if (fout < 0 && fin >= 0 && hs_d == 1'b0) fout = i;
        end
        force_fff = 1'b0;
        checks++; if (fin < 0 || fout - fin != 4) begin $display("FAIL hsync_fall_delay: got %0d want 4", fout - fin); errors++; end
    endtask

    task automatic test_frame_end();
        reset = 1'b1;
        cfg_small();
        row_cnt = 7;
        col_cnt = 0;
        repeat (2) tick();
        reset = 1'b0;
        run_to(5, 15, 400);
        tick();
        checks++; if (addr_s !== 20'd95 || rd_s !== 1'b1) begin $display("FAIL last_read_frame: got addr %0d rd %b want 95/1", addr_s, rd_s); errors++; end
        checks++; if (addr_5 !== 20'd95) begin $display("FAIL last_read_frame_lat5: got %0d want 95", addr_5); errors++; end
        run_to(6, 0, 50);
        checks++; if (dut_s.next_addr !== 20'd96) begin $display("FAIL next_addr_hblank: got %0d want 96", dut_s.next_addr); errors++; end
        tick();
        checks++; if (dut_s.next_addr !== 20'd0) begin $display("FAIL next_addr_vblank: got %0d want 0", dut_s.next_addr); errors++; end
        run_to(0, 0, 300);
        tick();
        checks++; if (addr_s !== 20'd0 || rd_s !== 1'b1) begin $display("FAIL next_frame_read0: got addr %0d rd %b want 0/1", addr_s, rd_s); errors++; end
        tick();
        checks++; if (addr_s !== 20'd1) begin $display("FAIL next_frame_read1: got %0d want 1", addr_s); errors++; end
    endtask

    task automatic test_latency5();
        run_to(0, 0, 300);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) begin checks++; if (col_s !== 12'h000) begin $display("FAIL lat2_pixel0: got %h want 000", col_s); errors++; end end
            if (k == 5) begin checks++; if (col_s !== 12'h001) begin $display("FAIL lat2_pixel1: got %h want 001", col_s); errors++; end end
            if (k == 6) begin checks++; if (col_5 !== 12'h000) begin $display("FAIL lat5_blank_before: got %h want 000", col_5); errors++; end end
            if (k == 7) begin checks++; if (col_5 !== 12'hA5C) begin $display("FAIL lat5_pixel0: got %h want a5c", col_5); errors++; end end
            if (k == 8) begin checks++; if (col_5 !== 12'hA5D) begin $display("FAIL lat5_pixel1: got %h want a5d", col_5); errors++; end end
        end
        run_to(0, 18, 50);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3) begin checks++; if (hs_s !== 1'b1) begin $display("FAIL lat2_hsync_early: got %b want 1", hs_s); errors++; end end
            if (k == 4) begin checks++; if (hs_s !== 1'b0) begin $display("FAIL lat2_hsync_fall: got %b want 0", hs_s); errors++; end end
            if (k == 6) begin checks++; if (hs_5 !== 1'b1) begin $display("FAIL lat5_hsync_early: got %b want 1", hs_5); errors++; end end
            if (k == 7) begin checks++; if (hs_5 !== 1'b0) begin $display("FAIL lat5_hsync_fall: got %b want 0", hs_5); errors++; end end
        end
    endtask

    task automatic test_reset_midline();
        run_to(3, 5, 300);
        reset = 1'b1;
        tick();
        checks++; if (addr_s !== 20'd0 || rd_s !== 1'b0) begin $display("FAIL midreset_read: got addr %0d rd %b want 0/0", addr_s, rd_s); errors++; end
        checks++; if (col_s !== 12'h000) begin $display("FAIL midreset_colour: got %h want 000", col_s); errors++; end
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1) begin $display("FAIL midreset_sync: got %b%b want 11", hs_s, vs_s); errors++; end
        checks++; if (dut_s.next_addr !== 20'd0) begin $display("FAIL midreset_next_addr: got %0d want 0", dut_s.next_addr); errors++; end
        checks++; if (rd_5 !== 1'b0 || col_5 !== 12'h000) begin $display("FAIL midreset_lat5: got rd %b col %h want 0/000", rd_5, col_5); errors++; end
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (col_s !== 12'h000 || hs_s !== 1'b1) begin $display("FAIL postreset_blank k%0d: got col %h hs %b want 000/1", k, col_s, hs_s); errors++; end
            if (k == 1) begin checks++; if (addr_s !== 20'd0 || rd_s !== 1'b1) begin $display("FAIL postreset_resume: got addr %0d rd %b want 0/1", addr_s, rd_s); errors++; end end
        end
        run_to(0, 0, 300);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin checks++; if (addr_s !== 20'd0 || rd_s !== 1'b1) begin $display("FAIL postreset_frame_read0: got addr %0d rd %b want 0/1", addr_s, rd_s); errors++; end end
            if (k == 4) begin checks++; if (col_s !== 12'h000) begin $display("FAIL postreset_pixel0: got %h want 000", col_s); errors++; end end
            if (k == 5) begin checks++; if (col_s !== 12'h001) begin $display("FAIL postreset_pixel1: got %h want 001", col_s); errors++; end end
            if (k == 6) begin checks++; if (col_s !== 12'h002) begin $display("FAIL postreset_pixel2: got %h want 002", col_s); errors++; end end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        visible   = 1'b0;
        hsync     = 1'b1;
        vsync     = 1'b1;
        column    = 10'd0;
        row       = 10'd0;
        force_fff = 1'b0;
        cfg_big();
        test_reset();
        test_first_pixel();
        test_line_boundary();
        test_alignment();
        test_frame_end();
        test_latency5();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
